// File: rtl/sram_like_bridge.sv
// sram_like_bridge: converts a fixed-latency SRAM-style core port into a
// req/addr_ok/data_ok handshake bus, holding the pipeline via stallreq.
// Optional feature macro: BRIDGE_TIMEOUT_EN (WAIT-state timeout with err pulse).
module sram_like_bridge #(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_en,
  input  logic [3:0]  cpu_wen,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        stallreq,
  output logic        req,
  output logic        wr,
  output logic [1:0]  size,
  output logic [31:0] addr,
  output logic [31:0] wdata,
  input  logic        addr_ok,
  input  logic        data_ok,
  input  logic [31:0] rdata,
  output logic        err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [1:0]  map_size;
  logic [1:0]  map_lo;
  logic        capture;
  logic        timeout;

`ifdef BRIDGE_TIMEOUT_EN
  localparam int unsigned CNT_W = 16;
  logic [CNT_W-1:0] cnt;
  assign timeout = (state == WAIT) && !data_ok &&
                   (cnt == CNT_W'(TIMEOUT_CYC - 1));
`else
  assign timeout = 1'b0;
`endif

  // Byte-enable pattern to bus transfer size and low address bits.
  always_comb begin
    map_size = 2'd2;
    map_lo   = 2'b00;
    case (cpu_wen)
      4'b0011: begin map_size = 2'd1; map_lo = 2'b00; end
      4'b1100: begin map_size = 2'd1; map_lo = 2'b10; end
      4'b0001: begin map_size = 2'd0; map_lo = 2'b00; end
      4'b0010: begin map_size = 2'd0; map_lo = 2'b01; end
      4'b0100: begin map_size = 2'd0; map_lo = 2'b10; end
      4'b1000: begin map_size = 2'd0; map_lo = 2'b11; end
      default: begin map_size = 2'd2; map_lo = 2'b00; end
    endcase
  end

  // Next-state logic; capture marks the cycle a read response is taken.
  always_comb begin
    state_next = state;
    capture    = 1'b0;
    case (state)
      IDLE: if (cpu_en) state_next = REQ;
      REQ: begin
        if (addr_ok && data_ok) begin
          state_next = DONE;
          capture    = !wr;
        end else if (addr_ok) begin
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (data_ok) begin
          state_next = DONE;
          capture    = !wr;
        end else if (timeout) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Bus request fields: latched on leaving IDLE and frozen until the transfer ends.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req   <= 1'b0;
      wr    <= 1'b0;
      size  <= 2'd0;
      addr  <= '0;
      wdata <= '0;
    end else begin
      req <= (state_next == REQ);
      if (state == IDLE && cpu_en) begin
        wr    <= |cpu_wen;
        size  <= map_size;
        addr  <= {cpu_addr[31:2], map_lo};
        wdata <= cpu_wdata;
      end
    end
  end

  // Read data held for the core; writes never disturb it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                 cpu_rdata <= '0;
    else if (capture)         cpu_rdata <= rdata;
    else if (timeout && !wr)  cpu_rdata <= 32'hDEAD_BEEF;
  end

`ifdef BRIDGE_TIMEOUT_EN
  // WAIT-cycle counter and one-cycle err pulse on forced completion.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
      err <= 1'b0;
    end else begin
      err <= timeout;
      if (state != WAIT) cnt <= '0;
      else               cnt <= cnt + 1'b1;
    end
  end
`else
  assign err = 1'b0;
`endif

  assign stallreq = cpu_en && (state != DONE);

endmodule

// File: tb/tb_sram_like_bridge.sv
// Directed-vector bench for sram_like_bridge.
module tb_sram_like_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_en;
  logic [3:0]  cpu_wen;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        stallreq;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;
  logic        err;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  sram_like_bridge #(.TIMEOUT_CYC(4)) dut (
    .clk(clk), .rst(rst),
    .cpu_en(cpu_en), .cpu_wen(cpu_wen), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .stallreq(stallreq),
    .req(req), .wr(wr), .size(size), .addr(addr), .wdata(wdata),
    .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    cpu_en = 1'b0; cpu_wen = 4'b0000; addr_ok = 1'b0; data_ok = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    idle_bus();
    cpu_addr = '0; cpu_wdata = '0; rdata = '0;
    tick(); tick();
    rst = 1'b1;
    tick();

    // Reset state
    chk("rst_req", {31'd0, req}, 32'd0);
    chk("rst_wr", {31'd0, wr}, 32'd0);
    chk("rst_size", {30'd0, size}, 32'd0);
    chk("rst_addr", addr, 32'd0);
    chk("rst_wdata", wdata, 32'd0);
    chk("rst_cpu_rdata", cpu_rdata, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_stall", {31'd0, stallreq}, 32'd0);

    // T1: read, addr_ok and data_ok in the same REQ cycle
    cpu_en = 1'b1; cpu_wen = 4'b0000; cpu_addr = 32'h1FC0_0006;
    #1 chk("t1_stall_idle", {31'd0, stallreq}, 32'd1);
    tick();
    chk("t1_req", {31'd0, req}, 32'd1);
    chk("t1_addr", addr, 32'h1FC0_0004);
    chk("t1_size", {30'd0, size}, 32'd2);
    chk("t1_wr", {31'd0, wr}, 32'd0);
    addr_ok = 1'b1; data_ok = 1'b1; rdata = 32'h1234_5678;
    tick();
    chk("t1_done_stall", {31'd0, stallreq}, 32'd0);
    chk("t1_done_req", {31'd0, req}, 32'd0);
    chk("t1_rdata", cpu_rdata, 32'h1234_5678);
    idle_bus();
    tick();

    // T2: byte write, addr_ok after 3 REQ cycles, data_ok after 5 more
    cpu_en = 1'b1; cpu_wen = 4'b0100; cpu_addr = 32'h8000_0010; cpu_wdata = 32'h00AB_0000;
    rdata = 32'h5555_5555;
    tick();
    chk("t2_wr", {31'd0, wr}, 32'd1);
    chk("t2_size", {30'd0, size}, 32'd0);
    chk("t2_addr", addr, 32'h8000_0012);
    chk("t2_wdata", wdata, 32'h00AB_0000);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("t2_req_hold", {31'd0, req}, 32'd1);
      chk("t2_stall_req", {31'd0, stallreq}, 32'd1);
    end
    addr_ok = 1'b1;
    tick();
    addr_ok = 1'b0;
    chk("t2_wait_req", {31'd0, req}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk("t2_stall_wait", {31'd0, stallreq}, 32'd1);
      tick();
    end
    chk("t2_stall_wait_last", {31'd0, stallreq}, 32'd1);
    data_ok = 1'b1;
    tick();
    chk("t2_done_stall", {31'd0, stallreq}, 32'd0);
    chk("t2_rdata_kept", cpu_rdata, 32'h1234_5678);
    idle_bus();
    tick();

    // T3: half-word write; fields frozen while cpu_addr/wen change
    cpu_en = 1'b1; cpu_wen = 4'b1100; cpu_addr = 32'h0000_0100; cpu_wdata = 32'hBEEF_0000;
    tick();
    chk("t3_size", {30'd0, size}, 32'd1);
    chk("t3_addr", addr, 32'h0000_0102);
    cpu_addr = 32'hFFFF_FFF0; cpu_wen = 4'b0001; cpu_wdata = 32'h0000_0011;
    tick();
    chk("t3_frozen_addr", addr, 32'h0000_0102);
    chk("t3_frozen_size", {30'd0, size}, 32'd1);
    chk("t3_frozen_wdata", wdata, 32'hBEEF_0000);
    addr_ok = 1'b1; data_ok = 1'b1;
    tick();
    idle_bus();
    tick();
    // irregular nonzero enable -> word-aligned word write
    cpu_en = 1'b1; cpu_wen = 4'b0101; cpu_addr = 32'h0000_0203;
    tick();
    chk("t3b_size", {30'd0, size}, 32'd2);
    chk("t3b_addr", addr, 32'h0000_0200);
    addr_ok = 1'b1; data_ok = 1'b1;
    tick();
    idle_bus();
    tick();

    // T4: spurious data_ok in IDLE and in REQ before addr_ok; cpu_en drop mid-transfer
    data_ok = 1'b1; rdata = 32'h1111_1111;
    tick();
    chk("t4_idle_dok", cpu_rdata, 32'h1234_5678);
    chk("t4_idle_req", {31'd0, req}, 32'd0);
    cpu_en = 1'b1; cpu_wen = 4'b0000; cpu_addr = 32'h0000_0040;
    tick();
    chk("t4_req", {31'd0, req}, 32'd1);
    tick();
    chk("t4_req_dok_ignored", cpu_rdata, 32'h1234_5678);
    chk("t4_req_still", {31'd0, req}, 32'd1);
    data_ok = 1'b0; addr_ok = 1'b1;
    tick();
    addr_ok = 1'b0; cpu_en = 1'b0;
    #1 chk("t4_stall_follows_en", {31'd0, stallreq}, 32'd0);
    data_ok = 1'b1; rdata = 32'hCAFE_F00D;
    tick();
    chk("t4_rdata", cpu_rdata, 32'hCAFE_F00D);
    idle_bus();
    tick();

    // T5: reset in WAIT, then late data_ok is dropped
    cpu_en = 1'b1; cpu_wen = 4'b0000; cpu_addr = 32'h0000_0080;
    tick();
    addr_ok = 1'b1;
    tick();
    addr_ok = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("t5_rst_req", {31'd0, req}, 32'd0);
    chk("t5_rst_rdata", cpu_rdata, 32'd0);
    tick();
    rst = 1'b1; cpu_en = 1'b0;
    data_ok = 1'b1; rdata = 32'hFFFF_FFFF;
    tick();
    chk("t5_late_idle", cpu_rdata, 32'd0);
    cpu_en = 1'b1;
    tick();
    chk("t5_new_req", {31'd0, req}, 32'd1);
    tick();
    chk("t5_late_req", cpu_rdata, 32'd0);
    data_ok = 1'b0; addr_ok = 1'b1;
    tick();
    addr_ok = 1'b0; data_ok = 1'b1; rdata = 32'h0BAD_F00D;
    tick();
    chk("t5_recover", cpu_rdata, 32'h0BAD_F00D);
    idle_bus();
    tick();

`ifdef BRIDGE_TIMEOUT_EN
    // T6: timeout after 4 WAIT cycles
    cpu_en = 1'b1; cpu_wen = 4'b0000; cpu_addr = 32'h0000_0100;
    tick();
    addr_ok = 1'b1;
    tick();
    addr_ok = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t6_err_low", {31'd0, err}, 32'd0);
      chk("t6_stall_wait", {31'd0, stallreq}, 32'd1);
    end
    tick();
    chk("t6_err", {31'd0, err}, 32'd1);
    chk("t6_rdata", cpu_rdata, 32'hDEAD_BEEF);
    chk("t6_stall_done", {31'd0, stallreq}, 32'd0);
    idle_bus();
    tick();
    chk("t6_err_pulse", {31'd0, err}, 32'd0);
`else
    chk("err_tied", {31'd0, err}, 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
